// File: rtl/reg_file_sb.sv
// Register file with per-register busy (scoreboard) bits, write-to-read bypass,
// flush of all reservations and a registered count of outstanding results.
module reg_file_sb #(
    parameter int DEPTH    = 32,
    parameter int BITS     = 64,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   readAddr,
    output logic [NREAD*BITS-1:0] readData,
    output logic [NREAD-1:0]      readBusy,
    input  logic [AW-1:0]         writeAddr,
    input  logic [BITS-1:0]       writeData,
    input  logic                  writeEn,
    input  logic [AW-1:0]         reserveAddr,
    input  logic                  reserveEn,
    input  logic                  flush,
    output logic [AW:0]           pendingCount,
    output logic                  stall
);

    logic [BITS-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [AW:0]      pend_q, pend_d;

    logic wr_ok, rsv_ok;

    // Writes and reservations aimed at the hardwired zero register have no effect.
    assign wr_ok  = writeEn   && !((ZERO_REG != 0) && (writeAddr   == '0));
    assign rsv_ok = reserveEn && !((ZERO_REG != 0) && (reserveAddr == '0));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_ok)  busy_d[writeAddr]   = 1'b0;
            // Applied after the clear so a same-cycle new producer keeps the bit set.
            if (rsv_ok) busy_d[reserveAddr] = 1'b1;
        end
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_d = pend_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data array is reset on purpose; reads must return zero after reset.
            regs_q <= '{default: '0};
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            if (wr_ok) regs_q[writeAddr] <= writeData;
            busy_q <= busy_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          bypass;
        readData = '0;
        readBusy = '0;
        for (int k = 0; k < NREAD; k++) begin
            addr    = readAddr[k*AW +: AW];
            is_zero = (ZERO_REG != 0) && (addr == '0);
            bypass  = wr_ok && (writeAddr == addr);
            if (is_zero) begin
                readData[k*BITS +: BITS] = '0;
            end else if (bypass) begin
                readData[k*BITS +: BITS] = writeData;
            end else begin
                readData[k*BITS +: BITS] = regs_q[addr];
            end
            readBusy[k] = !is_zero && !bypass && busy_q[addr];
        end
    end

    assign stall        = |readBusy;
    assign pendingCount = pend_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_reg_file_sb;

    localparam int DEPTH = 32;
    localparam int BITS  = 64;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREAD*AW-1:0]   readAddr;
    logic [NREAD*BITS-1:0] readData;
    logic [NREAD-1:0]      readBusy;
    logic [AW-1:0]         writeAddr;
    logic [BITS-1:0]       writeData;
    logic                  writeEn;
    logic [AW-1:0]         reserveAddr;
    logic                  reserveEn;
    logic                  flush;
    logic [AW:0]           pendingCount;
    logic                  stall;

    always #5 clk = ~clk;

    reg_file_sb #(.DEPTH(DEPTH), .BITS(BITS), .NREAD(NREAD), .ZERO_REG(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .readAddr     (readAddr),
        .readData     (readData),
        .readBusy     (readBusy),
        .writeAddr    (writeAddr),
        .writeData    (writeData),
        .writeEn      (writeEn),
        .reserveAddr  (reserveAddr),
        .reserveEn    (reserveEn),
        .flush        (flush),
        .pendingCount (pendingCount),
        .stall        (stall)
    );

    // Reference model: plain arrays of register contents and reservation flags.
    logic [BITS-1:0] m_data [DEPTH];
    bit              m_busy [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [BITS-1:0] rd(input int k);
        return readData[k*BITS +: BITS];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (writeEn && writeAddr != 0) m_data[writeAddr] = writeData;
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else begin
                if (writeEn) m_busy[writeAddr] = 1'b0;
                if (reserveEn && reserveAddr != 0) m_busy[reserveAddr] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit any_busy = 1'b0;
        for (int k = 0; k < NREAD; k++) begin
            int a = int'(readAddr[k*AW +: AW]);
            logic [BITS-1:0] exp_d;
            bit exp_b;
            if (a == 0) begin
                exp_d = '0;
                exp_b = 1'b0;
            end else if (writeEn && int'(writeAddr) == a) begin
                exp_d = writeData;
                exp_b = 1'b0;
            end else begin
                exp_d = m_data[a];
                exp_b = m_busy[a];
            end
            any_busy |= exp_b;
            check($sformatf("%s_data%0d", tag, k), rd(k), exp_d);
            check($sformatf("%s_busy%0d", tag, k), {63'd0, readBusy[k]}, {63'd0, exp_b});
        end
        check({tag, "_pending"}, {58'd0, pendingCount}, BITS'(m_count()));
        check({tag, "_stall"}, {63'd0, stall}, {63'd0, any_busy});
    endtask

    // One cycle: check current outputs against the model, clock, advance the model.
    task automatic step(input string tag);
        #1 check_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int ra0, input int ra1);
        rst = 1'b0; writeEn = 1'b0; reserveEn = 1'b0; flush = 1'b0;
        writeAddr = '0; writeData = '0; reserveAddr = '0;
        readAddr = {AW'(ra1), AW'(ra0)};
    endtask

    initial begin
        idle(0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++) begin
            readAddr = {AW'(DEPTH - 1 - a), AW'(a)};
            #1;
            check("rst_data0", rd(0), '0);
            check("rst_data1", rd(1), '0);
            check("rst_busy", {62'd0, readBusy}, '0);
            check("rst_stall", {63'd0, stall}, '0);
        end
        check("rst_pending", {58'd0, pendingCount}, '0);

        idle(0, 0);
        writeEn = 1'b1; writeAddr = 5; writeData = 64'hDEAD_BEEF;
        step("w5");
        idle(5, 0);
        #1 check("x5_data", rd(0), 64'hDEAD_BEEF);
        check("x5_busy", {63'd0, readBusy[0]}, '0);
        step("x5");

        idle(0, 7);
        writeEn = 1'b1; writeAddr = 7; writeData = 64'h1234;
        #1 check("byp_data", rd(1), 64'h1234);
        check("byp_busy", {63'd0, readBusy[1]}, '0);
        step("byp");

        idle(0, 0);
        reserveEn = 1'b1; reserveAddr = 3;
        step("rsv3");
        idle(3, 0);
        #1 check("x3_busy", {63'd0, readBusy[0]}, 64'd1);
        check("x3_stall", {63'd0, stall}, 64'd1);
        check("x3_pending", {58'd0, pendingCount}, 64'd1);
        writeEn = 1'b1; writeAddr = 3; writeData = 64'h55;
        step("w3");
        idle(3, 0);
        #1 check("x3_clr_busy", {63'd0, readBusy[0]}, '0);
        check("x3_clr_pending", {58'd0, pendingCount}, '0);
        check("x3_clr_data", rd(0), 64'h55);
        step("x3");

        idle(0, 0);
        reserveEn = 1'b1; reserveAddr = 9;
        writeEn = 1'b1; writeAddr = 9; writeData = 64'hAA;
        step("rw9");
        idle(9, 0);
        #1 check("x9_data", rd(0), 64'hAA);
        check("x9_busy", {63'd0, readBusy[0]}, 64'd1);
        check("x9_pending", {58'd0, pendingCount}, 64'd1);
        reserveEn = 1'b1; reserveAddr = 9;
        step("rsv9_again");
        idle(9, 0);
        #1 check("x9_rersv_pending", {58'd0, pendingCount}, 64'd1);
        writeEn = 1'b1; writeAddr = 9; writeData = 64'hAB;
        step("w9");

        idle(0, 0);
        writeEn = 1'b1; writeAddr = 0; writeData = 64'hFFFF;
        reserveEn = 1'b1; reserveAddr = 0;
        step("x0");
        idle(0, 0);
        #1 check("x0_data", rd(0), '0);
        check("x0_busy", {63'd0, readBusy[0]}, '0);
        check("x0_pending", {58'd0, pendingCount}, '0);
        step("x0_rd");

        idle(0, 0); reserveEn = 1'b1; reserveAddr = 1; step("rsv1");
        idle(0, 0); reserveEn = 1'b1; reserveAddr = 2; step("rsv2");
        idle(0, 0); reserveEn = 1'b1; reserveAddr = 4; step("rsv4");
        idle(0, 0);
        #1 check("fl_pre_pending", {58'd0, pendingCount}, 64'd3);
        flush = 1'b1;
        writeEn = 1'b1; writeAddr = 2; writeData = 64'h7;
        reserveEn = 1'b1; reserveAddr = 6;
        step("flush");
        idle(2, 1);
        #1 check("fl_pending", {58'd0, pendingCount}, '0);
        check("fl_busy", {62'd0, readBusy}, '0);
        check("fl_x2", rd(0), 64'h7);
        readAddr = {AW'(6), AW'(4)};
        #1 check("fl_busy46", {62'd0, readBusy}, '0);
        step("fl_rd");

        idle(0, 0); reserveEn = 1'b1; reserveAddr = 8; step("rsv8");
        idle(0, 0);
        rst = 1'b1;
        writeEn = 1'b1; writeAddr = 10; writeData = 64'h99;
        reserveEn = 1'b1; reserveAddr = 11;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        idle(2, 5);
        #1 check("rst2_x2", rd(0), '0);
        check("rst2_x5", rd(1), '0);
        check("rst2_pending", {58'd0, pendingCount}, '0);
        readAddr = {AW'(11), AW'(10)};
        #1 check("rst2_x10", rd(0), '0);
        check("rst2_busy", {62'd0, readBusy}, '0);
        check("rst2_stall", {63'd0, stall}, '0);
        step("rst2");

        for (int n = 0; n < 4000; n++) begin
            bit narrow = ($urandom_range(1) == 0);
            int amax   = narrow ? 7 : DEPTH - 1;
            rst         = ($urandom_range(199) == 0);
            flush       = ($urandom_range(24) == 0);
            writeEn     = ($urandom_range(2) == 0);
            reserveEn   = ($urandom_range(1) == 0);
            writeAddr   = AW'($urandom_range(amax));
            reserveAddr = AW'($urandom_range(amax));
            writeData   = {$urandom, $urandom};
            readAddr    = {AW'($urandom_range(amax)), AW'($urandom_range(amax))};
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
